// File: rtl/ab_rr_arbiter.sv
// Two-channel round-robin arbiter with a registered output beat; 1-cycle latency, full throughput.
// Backpressure: both channel readies drop while a held output beat is stalled by downstream.
module ab_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic             i_a_valid,
  output logic             o_a_ready,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_b_valid,
  output logic             o_b_ready,
  output logic [WIDTH-1:0] o_y,
  output logic             o_sel,
  output logic             o_y_valid,
  input  logic             i_y_ready,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt_a,
  output logic [CNT_W-1:0] o_cnt_b
);

  logic prio;
  logic can_accept;
  logic grant_a;
  logic grant_b;
  logic xfer_a;
  logic xfer_b;

  // prio = 0 prefers A; a lone requester wins regardless of prio.
  assign can_accept = !o_y_valid || i_y_ready;
  assign grant_a    = i_a_valid && (!i_b_valid || !prio);
  assign grant_b    = i_b_valid && (!i_a_valid || prio);
  assign o_a_ready  = can_accept && grant_a;
  assign o_b_ready  = can_accept && grant_b;
  assign xfer_a     = i_a_valid && o_a_ready;
  assign xfer_b     = i_b_valid && o_b_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_y       <= '0;
      o_sel     <= 1'b0;
      o_y_valid <= 1'b0;
      prio      <= 1'b0;
    end else if (xfer_a) begin
      o_y       <= i_a;
      o_sel     <= 1'b0;
      o_y_valid <= 1'b1;
      prio      <= 1'b1;
    end else if (xfer_b) begin
      o_y       <= i_b;
      o_sel     <= 1'b1;
      o_y_valid <= 1'b1;
      prio      <= 1'b0;
    end else if (i_y_ready) begin
      o_y_valid <= 1'b0;
    end
  end

  // Clear wins over a same-cycle increment; counts stick at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cnt_a <= '0;
      o_cnt_b <= '0;
    end else if (i_clr) begin
      o_cnt_a <= '0;
      o_cnt_b <= '0;
    end else begin
      if (xfer_a && (o_cnt_a != {CNT_W{1'b1}})) o_cnt_a <= o_cnt_a + CNT_W'(1);
      if (xfer_b && (o_cnt_b != {CNT_W{1'b1}})) o_cnt_b <= o_cnt_b + CNT_W'(1);
    end
  end

endmodule

// File: doc/ab_rr_arbiter.md
# ab_rr_arbiter

Two-channel round-robin arbiter and output register that feeds the 8-bit 2:1 selector stage. Each of two producer channels (A, B) presents a byte with a valid/ready handshake; the block grants one channel per cycle and registers the winning byte together with the select value that identifies its source. The result is presented downstream on a valid/ready handshake. Per-channel saturating beat counters give debug visibility.

## Interface

- WIDTH, 8, data width of each channel and of o_y
- CNT_W, 16, width of each beat counter

- i_clk  in  1  sole clock, rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_a  in  WIDTH  channel A data
- i_a_valid  in  1  channel A data valid
- o_a_ready  out  1  channel A accepted this cycle when high with i_a_valid
- i_b  in  WIDTH  channel B data
- i_b_valid  in  1  channel B data valid
- o_b_ready  out  1  channel B accepted this cycle when high with i_b_valid
- o_y  out  WIDTH  registered winning data
- o_sel  out  1  source of o_y (0 = A, 1 = B); drives the selector's i_sel
- o_y_valid  out  1  o_y/o_sel hold a beat
- i_y_ready  in  1  downstream accepts the beat
- i_clr  in  1  synchronous clear of both counters
- o_cnt_a  out  CNT_W  beats accepted from A, saturating
- o_cnt_b  out  CNT_W  beats accepted from B, saturating

One clock; reset is asynchronous and active-low.

## Operation

- State: priority bit prio (0 = A preferred), output register {o_y, o_sel, o_y_valid}, two counters.
- can_accept = !o_y_valid | i_y_ready. The output stage is full-throughput, with no bubble under continuous ready.
- Grant, combinational:
  - grant_a = i_a_valid & (!i_b_valid | !prio).
  - grant_b = i_b_valid & (!i_a_valid | prio).
  - At most one of grant_a and grant_b is high.
- o_a_ready = can_accept & grant_a; o_b_ready = can_accept & grant_b. Ready depends on valid; producers must not make valid depend on ready.
- Transfer on a channel when its valid and ready are both high. Then:
  - o_y <= channel data.
  - o_sel <= 0 for A, 1 for B.
  - o_y_valid <= 1.
  - prio <= 1 after an A grant, 0 after a B grant.
- Single requester: it wins regardless of prio, and prio still moves to the other channel.
- No transfer, with o_y_valid & i_y_ready: o_y_valid <= 0. o_y and o_sel keep their last value.
- No transfer, with o_y_valid & !i_y_ready: o_y, o_sel and o_y_valid hold stable. A producer's valid/data must also hold until accepted.
- prio changes only on a transfer.
- Counters:
  - Increment on a transfer from the matching channel.
  - Saturate at 2^CNT_W-1.
  - i_clr forces both counters to 0 and takes precedence over a same-cycle increment.

## Timing

- Reset values: o_y = 0, o_sel = 0, o_y_valid = 0, prio = 0, o_cnt_a = 0, o_cnt_b = 0.
- During reset, o_a_ready and o_b_ready evaluate to grant with can_accept = 1. Producers must hold valid low until reset is released.
- Latency: a beat accepted at edge N appears on o_y/o_y_valid after edge N, i.e. in cycle N+1.
- Throughput: one beat per cycle while i_y_ready = 1. Alternation is A,B,A,B when both channels are continuously valid.
- Downstream stall: both ready outputs are low, the output is frozen and prio does not advance.
- Simultaneous drain and refill (o_y_valid & i_y_ready & transfer): the new beat replaces the old one and o_y_valid stays 1.
- Reset mid-operation: the pending output beat is discarded and counters clear asynchronously. After release the first grant goes to A if both channels are valid.
- Counter saturation: at 0xFFFF (CNT_W = 16) a further transfer leaves the value at 0xFFFF. The transfer itself proceeds normally.

## Test plan

- Reset check: assert i_rst_n = 0 mid-stream with o_y_valid = 1. Required: outputs read 0 immediately, with no clock needed. After release with A and B both valid, the first beat has o_sel = 0.
- Contention: A = 0x11 and B = 0x22 both continuously valid, i_y_ready = 1. Required: from the cycle after the first accept, o_y reads 0x11, 0x22, 0x11, 0x22 with o_sel 0,1,0,1, and o_y_valid stays high.
- Single channel: only B valid, streaming 0x01..0x04, i_y_ready = 1. Required: every beat is accepted back-to-back with o_sel = 1 and o_cnt_b = 4. A later A+B contention grants A first.
- Backpressure: hold i_y_ready = 0 for 3 cycles with o_y = 0x5A valid and A, B valid. Required: o_y and o_sel are stable, both ready outputs are 0 and prio is unchanged. When i_y_ready rises, the granted beat follows with no bubble.
- Counters: preload to 0xFFFE via traffic (or force), then do 3 A transfers. Required: o_cnt_a reads 0xFFFF. Assert i_clr in the same cycle as an A transfer. Required: o_cnt_a = 0 the next cycle.
